// File: rtl/boom_display.sv
// boom_display
//   LED output stage for the self-destruct countdown. Shows the countdown
//   value steady while armed and blinks it in the warning band. When the
//   count reaches the boom value it latches an all-LED flashing pattern.
//   All timing is taken from the one-cycle tick strobe of the divider stage.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-clk strobe (nominally every 10 ms)
//   cnt_in     countdown value from the counter stage
//   in_combat  debounced combat level; 0 disarms
//   in_danger  debounced danger level; enables blinking in the warning band
//   leds       registered LED drive
//   boomed     registered, high while in BOOM
//   warn       registered, high while in WARN
module boom_display #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned WARN_VAL  = 7,
  parameter int unsigned BOOM_VAL  = 10,
  parameter int unsigned WARN_HALF = 25,
  parameter int unsigned BOOM_HALF = 10,
  parameter int unsigned BOOM_MIN  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             in_combat,
  input  logic             in_danger,
  output logic [CNT_W-1:0] leds,
  output logic             boomed,
  output logic             warn
);

  localparam int unsigned HALF_MAX = (WARN_HALF > BOOM_HALF) ? WARN_HALF : BOOM_HALF;
  localparam int unsigned BW       = (HALF_MAX > 1) ? $clog2(HALF_MAX + 1) : 1;
  localparam int unsigned MW       = $clog2(BOOM_MIN + 1);

  // Thresholds truncated to CNT_W so the compare is unsigned at input width.
  localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_VAL);
  localparam logic [CNT_W-1:0] BOOM_C    = CNT_W'(BOOM_VAL);
  localparam logic [BW-1:0]    WARN_LAST = BW'(WARN_HALF - 1);
  localparam logic [BW-1:0]    BOOM_LAST = BW'(BOOM_HALF - 1);
  localparam logic [MW-1:0]    MIN_C     = MW'(BOOM_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WARN,
    S_BOOM
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;     // blink half-period counter
  logic             phase_q, phase_d;   // blink phase, 1 = lit
  logic [MW-1:0]    mcnt_q, mcnt_d;     // ticks spent in BOOM, saturating
  logic [CNT_W-1:0] leds_q, leds_d;
  logic             boomed_q, boomed_d;
  logic             warn_q, warn_d;

  logic             entry;
  logic             hold_met;
  logic             blink_run;
  logic [BW-1:0]    half_last;

  assign hold_met = (mcnt_q >= MIN_C);

  // Next-state decision
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_combat) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!in_combat)            state_d = S_IDLE;
        else if (cnt_in >= BOOM_C) state_d = S_BOOM;
        else if (cnt_in >= WARN_C) state_d = S_WARN;
      end
      S_WARN: begin
        if (!in_combat)            state_d = S_IDLE;
        else if (cnt_in >= BOOM_C) state_d = S_BOOM;
        else if (cnt_in <  WARN_C) state_d = S_ARMED;
      end
      S_BOOM: begin
        // Latched: cnt_in is ignored, disarm only honoured after the hold.
        if (hold_met && !in_combat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entry = (state_d != state_q);

  // Blink timer only runs while something is actually blinking; with
  // in_danger low in WARN the phase and its counter are frozen together.
  assign blink_run = (state_q == S_BOOM) || ((state_q == S_WARN) && in_danger);
  assign half_last = (state_q == S_BOOM) ? BOOM_LAST : WARN_LAST;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (entry) begin
      // A tick coinciding with the state entry is deliberately dropped.
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (blink_run && tick) begin
      if (bcnt_q == half_last) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    if (entry) begin
      mcnt_d = '0;
    end else if ((state_q == S_BOOM) && tick && !hold_met) begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  // Outputs are derived from the next state so that an input change is
  // visible on the outputs right after the edge that samples it.
  always_comb begin
    leds_d   = '0;
    boomed_d = 1'b0;
    warn_d   = 1'b0;
    unique case (state_d)
      S_IDLE:  leds_d = '0;
      S_ARMED: leds_d = cnt_in;
      S_WARN: begin
        warn_d = 1'b1;
        leds_d = (in_danger && !phase_d) ? '0 : cnt_in;
      end
      S_BOOM: begin
        boomed_d = 1'b1;
        leds_d   = phase_d ? '1 : '0;
      end
      default: leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      mcnt_q   <= '0;
      leds_q   <= '0;
      boomed_q <= 1'b0;
      warn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      mcnt_q   <= mcnt_d;
      leds_q   <= leds_d;
      boomed_q <= boomed_d;
      warn_q   <= warn_d;
    end
  end

  assign leds   = leds_q;
  assign boomed = boomed_q;
  assign warn   = warn_q;

endmodule

// File: tb/tb_boom_display.sv
module tb_boom_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] cnt_in;
  logic       in_combat;
  logic       in_danger;
  logic [3:0] leds;
  logic       boomed;
  logic       warn;

  boom_display #(
    .CNT_W    (4),
    .WARN_VAL (7),
    .BOOM_VAL (10),
    .WARN_HALF(25),
    .BOOM_HALF(10),
    .BOOM_MIN (100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .cnt_in   (cnt_in),
    .in_combat(in_combat),
    .in_danger(in_danger),
    .leds     (leds),
    .boomed   (boomed),
    .warn     (warn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         due;
    logic [3:0] leds;
    logic       boomed;
    logic       warn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  event imm_ev;

  task automatic push(input string nm, input int due, input logic [3:0] l,
                      input logic b, input logic w);
    exp_t e;
    e.name   = nm;
    e.due    = due;
    e.leds   = l;
    e.boomed = b;
    e.warn   = w;
    sb.push_back(e);
  endtask

  // Expected response after the coming rising edge.
  task automatic exp_next(input string nm, input logic [3:0] l,
                          input logic b, input logic w);
    push(nm, cyc + 1, l, b, w);
  endtask

  // Expected response right now, without any clock edge (async reset).
  task automatic exp_now(input string nm, input logic [3:0] l,
                         input logic b, input logic w);
    #1;
    push(nm, cyc, l, b, w);
    ->imm_ev;
    #1;
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are compared on the falling edge, or immediately on request.
  initial begin
    forever begin
      @(negedge clk or imm_ev);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        n_chk++;
        if ({leds, boomed, warn} !== {mon_e.leds, mon_e.boomed, mon_e.warn}) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got leds=%b boomed=%b warn=%b, expected leds=%b boomed=%b warn=%b",
                   mon_e.name, cyc, leds, boomed, warn, mon_e.leds, mon_e.boomed, mon_e.warn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  int k;

  initial begin
    rst_n = 1'b0; tick = 1'b0; in_combat = 1'b0; in_danger = 1'b0; cnt_in = 4'd0;
    adv();
    exp_now("reset", 4'h0, 1'b0, 1'b0);
    adv();
    rst_n = 1'b1;
    exp_next("idle_hold", 4'h0, 1'b0, 1'b0); adv();

    // Arming and the warning band boundary
    in_combat = 1'b1; cnt_in = 4'd3;
    exp_next("armed_3", 4'h3, 1'b0, 1'b0); adv();
    exp_next("armed_3_steady", 4'h3, 1'b0, 1'b0); adv();
    cnt_in = 4'd6;
    exp_next("armed_6", 4'h6, 1'b0, 1'b0); adv();
    cnt_in = 4'd7;
    exp_next("warn_7_enter", 4'h7, 1'b0, 1'b1); adv();
    cnt_in = 4'd6;
    exp_next("warn_back_armed", 4'h6, 1'b0, 1'b0); adv();

    // Warning blink; the tick on the entry cycle must not count
    cnt_in = 4'd8; in_danger = 1'b1; tick = 1'b1;
    exp_next("warn_entry", 4'h8, 1'b0, 1'b1); adv();
    k = 0;
    for (int c = 0; c < 120; c++) begin
      tick = (c % 2 == 0);
      if (tick) k++;
      exp_next("warn_blink", ((k / 25) % 2 == 0) ? 4'h8 : 4'h0, 1'b0, 1'b1);
      adv();
    end
    in_danger = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick = (c % 2 == 0);
      exp_next("warn_nodanger", 4'h8, 1'b0, 1'b1);
      adv();
    end
    tick = 1'b0;

    // Disarm from WARN
    in_combat = 1'b0;
    exp_next("warn_disarm", 4'h0, 1'b0, 1'b0); adv();
    in_combat = 1'b1; cnt_in = 4'd9;
    exp_next("rearm_9", 4'h9, 1'b0, 1'b0); adv();
    exp_next("warn_9", 4'h9, 1'b0, 1'b1); adv();

    // Boom at exactly BOOM_VAL, flash, disarm early, exit after the hold
    cnt_in = 4'd10; tick = 1'b1;
    exp_next("boom_entry", 4'hF, 1'b1, 1'b0); adv();
    cnt_in = 4'd0;
    for (k = 1; k <= 100; k++) begin
      tick = 1'b1;
      if (k == 40) in_combat = 1'b0;
      exp_next("boom_hold", ((k / 10) % 2 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0);
      adv();
    end
    exp_next("boom_exit", 4'h0, 1'b0, 1'b0); adv();
    tick = 1'b0;
    exp_next("idle_after_boom", 4'h0, 1'b0, 1'b0); adv();

    // Boom from a value above BOOM_VAL; hold counter must saturate, not wrap
    in_combat = 1'b1; cnt_in = 4'd15;
    exp_next("armed_15", 4'hF, 1'b0, 1'b0); adv();
    exp_next("boom_15", 4'hF, 1'b1, 1'b0); adv();
    cnt_in = 4'd0;
    for (k = 1; k <= 140; k++) begin
      tick = 1'b1;
      exp_next("boom_combat_on", ((k / 10) % 2 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0);
      adv();
    end
    in_combat = 1'b0;
    exp_next("boom_sat_exit", 4'h0, 1'b0, 1'b0); adv();
    tick = 1'b0;

    // Asynchronous reset in the middle of a flash
    in_combat = 1'b1; cnt_in = 4'd12;
    exp_next("armed_12", 4'hC, 1'b0, 1'b0); adv();
    exp_next("boom_12", 4'hF, 1'b1, 1'b0); adv();
    for (int c = 0; c < 5; c++) begin
      tick = 1'b1;
      exp_next("boom_pre_reset", 4'hF, 1'b1, 1'b0);
      adv();
    end
    tick = 1'b0;
    rst_n = 1'b0;
    exp_now("async_reset", 4'h0, 1'b0, 1'b0);
    exp_next("reset_held", 4'h0, 1'b0, 1'b0); adv();
    rst_n = 1'b1;
    exp_next("release_armed", 4'hC, 1'b0, 1'b0); adv();
    exp_next("release_boom", 4'hF, 1'b1, 1'b0); adv();

    repeat (3) adv();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
